// File: rtl/adder_subtractor.sv
// Registered WIDTH-bit two's-complement adder/subtractor built from a ripple-carry chain.
// It registers the result with carry, signed-overflow and zero flags, plus a one-cycle valid strobe.
module adder_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             valid
);

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             ovf_c;

  // The carry chain lives in a block-local variable.
  // This keeps the ripple from looking like a combinational loop on a module-level net.
  always_comb begin : chain
    logic [WIDTH:0]   cy;
    logic [WIDTH-1:0] bx;
    bx    = B ^ {WIDTH{M}};
    cy    = '0;
    cy[0] = M;
    sum_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_c[i]  = A[i] ^ bx[i] ^ cy[i];
      cy[i + 1] = (A[i] & bx[i]) | (cy[i] & (A[i] ^ bx[i]));
    end
    carry_c = cy[WIDTH];
    ovf_c   = cy[WIDTH] ^ cy[WIDTH - 1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b1;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        S <= sum_c;
        C <= carry_c;
        V <= ovf_c;
        Z <= (sum_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// Scoreboard bench for adder_subtractor: an arithmetic model queues the expected results,
// and a monitor compares each DUT result against the queue one cycle later.
module tb_adder_subtractor;
  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] A   = '0;
  logic [W-1:0] B   = '0;
  logic         M   = 1'b0;
  logic [W-1:0] S;
  logic         C, V, Z, valid;

  int   n_check = 0;
  int   n_pass  = 0;
  res_t sb[$];
  res_t held;
  logic exp_valid;

  adder_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .M(M),
    .S(S), .C(C), .V(V), .Z(Z), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Integer arithmetic reference, independent of the gate-level chain.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    res_t r;
    int ua, ub, sa, sb_, full, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sb_ = int'($signed(b));
    if (!m) begin
      full = ua + ub;
      r.c  = (full >= (1 << W));
      sr   = sa + sb_;
    end else begin
      full = ua - ub;
      r.c  = (ua >= ub);
      sr   = sa - sb_;
    end
    r.s = full[W-1:0];
    r.v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic m);
    @(negedge clk);
    rst = r; en = e; A = a; B = b; M = m;
  endtask

  // The monitor samples inputs at the edge, then checks outputs 1 time unit later.
  always @(posedge clk) begin
    if (rst) begin
      exp_valid = 1'b0;
      held      = '{s: '0, c: 1'b0, v: 1'b0, z: 1'b1};
      sb.delete();
    end else if (en) begin
      sb.push_back(model(A, B, M));
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check_eq("valid", 32'(valid), 32'(exp_valid));
    if (valid === 1'b1) begin
      if (sb.size() == 0) check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      else held = sb.pop_front();
    end
    check_eq("S", 32'(S), 32'(held.s));
    check_eq("C", 32'(C), 32'(held.c));
    check_eq("V", 32'(V), 32'(held.v));
    check_eq("Z", 32'(Z), 32'(held.z));
  end

  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 3, 2, 0);
    drive(0, 1, 8, 5, 0);
    drive(0, 1, 15, 1, 0);
    drive(0, 1, 7, 1, 0);
    drive(0, 1, 2, 2, 1);
    drive(0, 1, 4, 3, 1);
    drive(0, 1, 3, 5, 1);
    drive(0, 1, 8, 1, 1);
    drive(0, 0, 0, 0, 0);
    // Hold: one result, then three idle cycles with changing operands.
    drive(0, 1, 3, 2, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 9, 9, 1);
    // Back-to-back mixed modes.
    drive(0, 1, 12, 9, 1);
    drive(0, 1, 6, 6, 0);
    drive(0, 1, 0, 1, 1);
    drive(0, 1, 5, 4, 0);
    drive(0, 0, 0, 0, 0);
    // Reset overrides an operation presented in the same cycle.
    drive(0, 1, 9, 2, 0);
    drive(1, 1, 6, 1, 0);
    drive(0, 1, 6, 1, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom), 1'($urandom));
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end
endmodule
